dds_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer that drives the 24-bit frequency control word of the sine DDS.

---
 rtl/dds_sweep_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - frequency-sweep sequencer feeding the 24-bit DDS fcw
// Steps fcw from start to stop with a per-value dwell; single, repeat and triangle modes.
module dds_sweep_ctrl #(
   parameter int FCW_W   = 24,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [FCW_W-1:0]   cfg_start,
   input  logic [FCW_W-1:0]   cfg_stop,
   input  logic [FCW_W-1:0]   cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [1:0]         cfg_mode,
   input  logic               go,
   input  logic               abort,
   output logic [FCW_W-1:0]   fcw,
   output logic               sweep_active,
   output logic               step_stb,
   output logic               sweep_done
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [DWELL_W-1:0] DW_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
   localparam logic [FCW_W-1:0]   FCW_ONE = {{(FCW_W-1){1'b0}}, 1'b1};
   localparam logic               DIR_UP  = 1'b0;
   localparam logic               DIR_DN  = 1'b1;

   state_t             state_q;
   logic [FCW_W-1:0]   fcw_q;
   logic               active_q;
   logic               stb_q;
   logic               done_q;
   logic               cfg_loaded_q;
   logic               dir_q;
   logic [DWELL_W-1:0] cnt_q;

   logic [FCW_W-1:0]   start_q;
   logic [FCW_W-1:0]   stop_q;
   logic [FCW_W-1:0]   step_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [1:0]         mode_q;
   logic               single_q;

   logic [FCW_W-1:0]   dwell_unused_pad;
   logic [DWELL_W-1:0] dwell_nrm;
   logic [FCW_W-1:0]   step_nrm;
   logic               xfer;
   logic               launch;
   logic [FCW_W:0]     up_sum;
   logic [FCW_W:0]     dn_diff;
   logic [FCW_W-1:0]   up_d;
   logic [FCW_W-1:0]   dn_d;

   assign cfg_ready    = (state_q == S_IDLE);
   assign fcw          = fcw_q;
   assign sweep_active = active_q;
   assign step_stb     = stb_q;
   assign sweep_done   = done_q;

   assign xfer   = cfg_valid && (state_q == S_IDLE);
   assign launch = (state_q == S_IDLE) && go && !abort && cfg_loaded_q;

   // Zero dwell/step would stall the sweep, so both are promoted to one.
   always_comb begin
      dwell_unused_pad = '0;
      dwell_nrm = (cfg_dwell == '0) ? DW_ONE : cfg_dwell;
      step_nrm  = (cfg_step == '0) ? FCW_ONE : cfg_step;
   end

   // One extra bit catches carry/borrow so clamping never wraps through zero.
   always_comb begin
      up_sum  = {1'b0, fcw_q} + {1'b0, step_q};
      dn_diff = {1'b0, fcw_q} - {1'b0, step_q};
      up_d    = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[FCW_W-1:0];
      dn_d    = (dn_diff[FCW_W] || (dn_diff[FCW_W-1:0] <= start_q)) ? start_q
                                                                     : dn_diff[FCW_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         fcw_q        <= '0;
         active_q     <= 1'b0;
         stb_q        <= 1'b0;
         done_q       <= 1'b0;
         cfg_loaded_q <= 1'b0;
         dir_q        <= DIR_UP;
         cnt_q        <= '0;
         start_q      <= '0;
         stop_q       <= '0;
         step_q       <= '0;
         dwell_q      <= '0;
         mode_q       <= '0;
         single_q     <= 1'b0;
      end else begin
         stb_q  <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (xfer) begin
                  start_q      <= cfg_start;
                  stop_q       <= cfg_stop;
                  step_q       <= step_nrm;
                  dwell_q      <= dwell_nrm;
                  mode_q       <= cfg_mode;
                  single_q     <= (cfg_start >= cfg_stop);
                  cfg_loaded_q <= 1'b1;
               end
               // A config captured in the same cycle as go takes effect immediately.
               if (launch) begin
                  state_q  <= S_RUN;
                  active_q <= 1'b1;
                  stb_q    <= 1'b1;
                  dir_q    <= DIR_UP;
                  fcw_q    <= xfer ? cfg_start : start_q;
                  cnt_q    <= (xfer ? dwell_nrm : dwell_q) - DW_ONE;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state_q  <= S_IDLE;
                  active_q <= 1'b0;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - DW_ONE;
               end else begin
                  cnt_q <= dwell_q - DW_ONE;
                  if (single_q) begin
                     state_q  <= S_IDLE;
                     active_q <= 1'b0;
                     done_q   <= 1'b1;
                  end else if (dir_q == DIR_UP) begin
                     if (fcw_q == stop_q) begin
                        case (mode_q)
                           2'd1: begin
                              fcw_q <= start_q;
                              stb_q <= 1'b1;
                           end
                           2'd2: begin
                              dir_q <= DIR_DN;
                              fcw_q <= dn_d;
                              stb_q <= 1'b1;
                           end
                           default: begin
                              state_q  <= S_IDLE;
                              active_q <= 1'b0;
                              done_q   <= 1'b1;
                           end
                        endcase
                     end else begin
                        fcw_q <= up_d;
                        stb_q <= 1'b1;
                     end
                  end else begin
                     if (fcw_q == start_q) begin
                        dir_q <= DIR_UP;
                        fcw_q <= up_d;
                     end else begin
                        fcw_q <= dn_d;
                     end
                     stb_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q  <= S_IDLE;
               active_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - self-checking bench for dds_sweep_ctrl
// Expected traces come from a value-list model expanded by dwell; one negedge process compares.
module tb_dds_sweep_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [23:0] cfg_start, cfg_stop, cfg_step;
   logic [15:0] cfg_dwell;
   logic [1:0]  cfg_mode;
   logic        go, abort;
   logic [23:0] fcw;
   logic        sweep_active, step_stb, sweep_done;

   dds_sweep_ctrl #(.FCW_W(24), .DWELL_W(16)) dut (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
      .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .go(go), .abort(abort),
      .fcw(fcw), .sweep_active(sweep_active), .step_stb(step_stb), .sweep_done(sweep_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] fcw;
      logic        stb;
      logic        act;
      logic        done;
      logic        rdy;
   } exp_t;

   exp_t   exp_q[$];
   exp_t   cur_e;
   string  lit_name[$];
   longint lit_act[$];
   longint lit_req[$];
   longint vals[$];
   int     checks = 0;
   int     errors = 0;
   int     stb_count = 0;
   int     stb_base;

   longint p_start, p_stop, p_step;
   int     p_dwell, p_mode;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur_e = exp_q.pop_front();
         chk("fcw", longint'(fcw), longint'(cur_e.fcw));
         chk("step_stb", longint'(step_stb), longint'(cur_e.stb));
         chk("sweep_active", longint'(sweep_active), longint'(cur_e.act));
         chk("sweep_done", longint'(sweep_done), longint'(cur_e.done));
         chk("cfg_ready", longint'(cfg_ready), longint'(cur_e.rdy));
      end
      while (lit_name.size() > 0)
         chk(lit_name.pop_front(), lit_act.pop_front(), lit_req.pop_front());
      if (step_stb) stb_count++;
   end

   task automatic lit(input string name, input longint act, input longint req);
      lit_name.push_back(name);
      lit_act.push_back(act);
      lit_req.push_back(req);
   endtask

   task automatic push_e(input longint f, input logic s, input logic a, input logic dn, input logic r);
      exp_t e;
      e.fcw  = 24'(f);
      e.stb  = s;
      e.act  = a;
      e.done = dn;
      e.rdy  = r;
      exp_q.push_back(e);
   endtask

   // Sequence of distinct fcw values the sweep must present, in order.
   task automatic gen_values(input longint st, input longint sp, input longint sc,
                             input int mode, input int maxn);
      longint s, v;
      s = (sc == 0) ? 1 : sc;
      vals.delete();
      v = st;
      vals.push_back(v);
      if (st >= sp) return;
      while (vals.size() < maxn) begin
         while (v != sp) begin
            v = (v + s >= sp) ? sp : v + s;
            vals.push_back(v);
         end
         if (mode == 0 || mode == 3) return;
         if (mode == 1) begin
            v = st;
            vals.push_back(v);
         end else begin
            while (v != st) begin
               v = (v <= st + s) ? st : v - s;
               vals.push_back(v);
            end
         end
      end
   endtask

   task automatic drain(input string name);
      int c = 0;
      while (exp_q.size() > 0 && c < 3000) begin
         @(posedge clk); #1;
         c++;
      end
      lit(name, longint'(c < 3000), 1);
   endtask

   task automatic load_cfg(input longint st, input longint sp, input longint sc,
                           input int dw, input int mode);
      int g = 0;
      @(negedge clk); #1;
      cfg_valid = 1'b1;
      cfg_start = 24'(st);
      cfg_stop  = 24'(sp);
      cfg_step  = 24'(sc);
      cfg_dwell = 16'(dw);
      cfg_mode  = 2'(mode);
      while (!cfg_ready && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      lit("cfg_ready_at_load", longint'(cfg_ready), 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic expect_sweep(input longint st, input longint sp, input longint sc,
                               input int dw, input int mode, input int go_len,
                               input int abort_at, input bit hold);
      int d, run_len, c;
      bit finite, aborted;
      longint last;
      d = (dw == 0) ? 1 : dw;
      finite = (st >= sp) || mode == 0 || mode == 3;
      gen_values(st, sp, sc, mode, ((abort_at < 0) ? 0 : abort_at) / d + 3);
      run_len = finite ? vals.size() * d : abort_at + 1;
      aborted = 1'b0;
      if (abort_at >= 0 && abort_at < run_len) begin
         run_len = abort_at + 1;
         aborted = 1'b1;
      end
      @(negedge clk); #1;
      go = 1'b1;
      for (int i = 0; i < run_len; i++)
         push_e(vals[i / d], (i % d) == 0, 1'b1, 1'b0, 1'b0);
      last = vals[(run_len - 1) / d];
      push_e(last, 1'b0, 1'b0, !aborted, 1'b1);
      repeat (3) push_e(last, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      if (hold) begin
         cfg_valid = 1'b1;
         cfg_start = 24'(p_start);
         cfg_stop  = 24'(p_stop);
         cfg_step  = 24'(p_step);
         cfg_dwell = 16'(p_dwell);
         cfg_mode  = 2'(p_mode);
      end
      c = 0;
      while (exp_q.size() > 0 && c < 3000) begin
         if (c >= go_len - 1) go = 1'b0;
         abort = aborted && (c == abort_at);
         @(posedge clk); #1;
         c++;
      end
      go = 1'b0;
      abort = 1'b0;
      lit("sweep_drain_bound", longint'(c < 3000), 1);
   endtask

   task automatic idle_expect(input longint f, input int n);
      @(negedge clk); #1;
      go = 1'b1;
      repeat (n) push_e(f, 1'b0, 1'b0, 1'b0, 1'b1);
      drain("idle_drain_bound");
      go = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      cfg_valid = 1'b0;
      cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;
      go = 1'b0;
      abort = 1'b0;

      gen_values(24'h001000, 24'h001400, 24'h000100, 0, 20);
      lit("model_single_len", vals.size(), 5);
      lit("model_single_v1", vals[1], 24'h001100);
      lit("model_single_v4", vals[4], 24'h001400);
      gen_values(24'hFFFF00, 24'hFFFFFF, 24'h000080, 0, 20);
      lit("model_clamp_len", vals.size(), 3);
      lit("model_clamp_v2", vals[2], 24'hFFFFFF);
      gen_values(24'h10, 24'h30, 24'h10, 2, 8);
      lit("model_tri_v3", vals[3], 24'h20);
      lit("model_tri_v4", vals[4], 24'h10);
      lit("model_tri_v5", vals[5], 24'h20);

      repeat (3) @(posedge clk);
      #1;
      lit("rst_fcw", longint'(fcw), 0);
      lit("rst_active", longint'(sweep_active), 0);
      lit("rst_cfg_ready", longint'(cfg_ready), 1);
      lit("rst_done", longint'(sweep_done), 0);
      @(negedge clk); #1;
      reset = 1'b1;

      idle_expect(0, 4);

      load_cfg(24'h001000, 24'h001400, 24'h000100, 3, 0);
      stb_base = stb_count;
      expect_sweep(24'h001000, 24'h001400, 24'h000100, 3, 0, 4, -1, 1'b0);
      lit("single_final_fcw", longint'(fcw), 24'h001400);
      lit("single_stb_count", longint'(stb_count - stb_base), 5);

      load_cfg(24'hFFFF00, 24'hFFFFFF, 24'h000080, 1, 0);
      expect_sweep(24'hFFFF00, 24'hFFFFFF, 24'h000080, 1, 0, 1, -1, 1'b0);
      lit("clamp_final_fcw", longint'(fcw), 24'hFFFFFF);

      p_start = 24'h001000; p_stop = 24'h001400; p_step = 24'h000100; p_dwell = 3; p_mode = 1;
      load_cfg(24'h10, 24'h30, 24'h10, 2, 2);
      expect_sweep(24'h10, 24'h30, 24'h10, 2, 2, 1, 17, 1'b1);
      cfg_valid = 1'b0;

      expect_sweep(24'h001000, 24'h001400, 24'h000100, 3, 1, 1, 22, 1'b0);
      lit("repeat_abort_fcw", longint'(fcw), 24'h001200);
      lit("repeat_abort_ready", longint'(cfg_ready), 1);

      load_cfg(24'h100, 24'h103, 0, 0, 0);
      expect_sweep(24'h100, 24'h103, 0, 0, 0, 1, -1, 1'b0);

      load_cfg(24'h500, 24'h500, 24'h10, 3, 1);
      expect_sweep(24'h500, 24'h500, 24'h10, 3, 1, 1, -1, 1'b0);
      load_cfg(24'h600, 24'h500, 1, 2, 2);
      expect_sweep(24'h600, 24'h500, 1, 2, 2, 1, -1, 1'b0);

      load_cfg(24'h001000, 24'h001400, 24'h000100, 3, 0);
      @(negedge clk); #1;
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      lit("pre_reset_fcw", longint'(fcw), 24'h001200);
      lit("pre_reset_active", longint'(sweep_active), 1);
      #2;
      reset = 1'b0;
      #1;
      lit("async_rst_fcw", longint'(fcw), 0);
      lit("async_rst_active", longint'(sweep_active), 0);
      lit("async_rst_ready", longint'(cfg_ready), 1);
      @(negedge clk); #1;
      reset = 1'b1;
      idle_expect(0, 5);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
